// File: rtl/decapsulation_if.sv
// Receive-side bundle for the decapsulator: GMII receive inputs and the
// decapsulated payload/status outputs.
interface decapsulation_if;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rxd;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        frame_start;
  logic        frame_end;
  logic        frame_good;
  logic [47:0] src_mac;
  logic [15:0] ethertype;

  modport master (
    output rx_dv, rx_er, rxd,
    input  data_out, data_valid, frame_start, frame_end, frame_good, src_mac, ethertype
  );

  modport slave (
    input  rx_dv, rx_er, rxd,
    output data_out, data_valid, frame_start, frame_end, frame_good, src_mac, ethertype
  );
endinterface

// File: rtl/decapsulation.sv
// GMII receive decapsulator: destination filter, header capture, FCS strip and
// frame status. Define DECAP_CRC_CHECK_EN to include the CRC-32 check.
module decapsulation #(
  parameter logic [47:0] MAC_ADDR    = 48'h023528fbdd66,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500
) (
  input  logic           eth_rx_clk,
  input  logic           arst_n,
  decapsulation_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DST, SRC, TYPE, PAYLOAD, DROP} state_t;

  // Counter includes the 4 FCS bytes, so the length window is shifted by 4.
  localparam logic [10:0] MIN_CNT = 11'(MIN_PAYLOAD + 4);
  localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD + 4);
  localparam logic [10:0] CNT_SAT = 11'd2047;

  state_t           state_r, state_s;
  logic [2:0]       hdr_cnt_r, hdr_cnt_s;
  logic [47:0]      dst_r, dst_s, dst_next_s;
  logic [47:0]      src_mac_r, src_mac_s;
  logic [15:0]      ethertype_r, ethertype_s;
  logic [10:0]      byte_cnt_r, byte_cnt_s;
  logic [3:0][7:0]  dl_r, dl_s;
  logic             err_r, err_s;
  logic             first_r, first_s;
  logic [7:0]       data_out_r, data_out_s;
  logic             data_valid_r, data_valid_s;
  logic             frame_start_r, frame_start_s;
  logic             frame_end_r, frame_end_s;
  logic             frame_good_r, frame_good_s;
  logic             in_frame_s;
  logic             crc_ok_s;

  assign in_frame_s = (state_r == DST) || (state_r == SRC) ||
                      (state_r == TYPE) || (state_r == PAYLOAD);
  assign dst_next_s = {dst_r[39:0], bus.rxd};

`ifdef DECAP_CRC_CHECK_EN
  logic [31:0] crc_r, crc_s;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) begin
        c = (c >> 1) ^ 32'hEDB88320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // CRC next value: seeded on SFD, advanced on every byte from DST onward.
  always_comb begin
    crc_s = crc_r;
    if ((state_r == PREAMBLE) && bus.rx_dv && (bus.rxd == 8'hD5)) begin
      crc_s = 32'hFFFFFFFF;
    end else if (in_frame_s && bus.rx_dv) begin
      crc_s = crc32_byte(crc_r, bus.rxd);
    end else begin
      crc_s = crc_r;
    end
  end

  // CRC register.
  always_ff @(posedge eth_rx_clk or negedge arst_n) begin
    if (!arst_n) begin
      crc_r <= 32'hFFFFFFFF;
    end else begin
      crc_r <= crc_s;
    end
  end

  // Residue of a reflected CRC-32 run across its own FCS.
  assign crc_ok_s = (crc_r == 32'hDEBB20E3);
`else
  assign crc_ok_s = 1'b1;
`endif

  // Next-state and datapath/output next values.
  always_comb begin
    state_s       = state_r;
    hdr_cnt_s     = hdr_cnt_r;
    dst_s         = dst_r;
    src_mac_s     = src_mac_r;
    ethertype_s   = ethertype_r;
    byte_cnt_s    = byte_cnt_r;
    dl_s          = dl_r;
    err_s         = err_r;
    first_s       = first_r;
    data_out_s    = data_out_r;
    data_valid_s  = 1'b0;
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    frame_good_s  = 1'b0;

    if (in_frame_s && bus.rx_dv && bus.rx_er) begin
      err_s = 1'b1;
    end else begin
      err_s = err_r;
    end

    case (state_r)
      IDLE: begin
        if (bus.rx_dv && (bus.rxd == 8'h55)) begin
          state_s = PREAMBLE;
        end else begin
          state_s = IDLE;
        end
      end
      PREAMBLE: begin
        if (!bus.rx_dv) begin
          state_s = IDLE;
        end else if (bus.rxd == 8'h55) begin
          state_s = PREAMBLE;
        end else if (bus.rxd == 8'hD5) begin
          state_s    = DST;
          hdr_cnt_s  = 3'd0;
          err_s      = 1'b0;
          byte_cnt_s = 11'd0;
          first_s    = 1'b0;
        end else begin
          state_s = DROP;
        end
      end
      DST: begin
        if (!bus.rx_dv) begin
          state_s = IDLE;
        end else begin
          dst_s = dst_next_s;
          if (hdr_cnt_r == 3'd5) begin
            hdr_cnt_s = 3'd0;
            if ((dst_next_s == MAC_ADDR) || (dst_next_s == 48'hFFFFFFFFFFFF)) begin
              state_s = SRC;
            end else begin
              state_s = DROP;
            end
          end else begin
            hdr_cnt_s = hdr_cnt_r + 3'd1;
          end
        end
      end
      SRC, TYPE, PAYLOAD: begin
        if (!bus.rx_dv) begin
          state_s      = IDLE;
          first_s      = 1'b0;
          frame_end_s  = 1'b1;
          frame_good_s = !err_r && (byte_cnt_r >= MIN_CNT) &&
                         (byte_cnt_r <= MAX_CNT) && crc_ok_s;
        end else if (state_r == SRC) begin
          src_mac_s = {src_mac_r[39:0], bus.rxd};
          if (hdr_cnt_r == 3'd5) begin
            hdr_cnt_s = 3'd0;
            state_s   = TYPE;
          end else begin
            hdr_cnt_s = hdr_cnt_r + 3'd1;
          end
        end else if (state_r == TYPE) begin
          ethertype_s = {ethertype_r[7:0], bus.rxd};
          if (hdr_cnt_r == 3'd1) begin
            hdr_cnt_s = 3'd0;
            state_s   = PAYLOAD;
            first_s   = 1'b1;
          end else begin
            hdr_cnt_s = hdr_cnt_r + 3'd1;
          end
        end else begin
          // A byte leaves the delay line only once four newer bytes sit behind it.
          if (byte_cnt_r >= 11'd4) begin
            data_out_s    = dl_r[3];
            data_valid_s  = 1'b1;
            frame_start_s = first_r;
            first_s       = 1'b0;
          end else begin
            data_valid_s = 1'b0;
          end
          dl_s = {dl_r[2:0], bus.rxd};
          if (byte_cnt_r != CNT_SAT) begin
            byte_cnt_s = byte_cnt_r + 11'd1;
          end else begin
            byte_cnt_s = byte_cnt_r;
          end
        end
      end
      DROP: begin
        if (!bus.rx_dv) begin
          state_s = IDLE;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge eth_rx_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge eth_rx_clk or negedge arst_n) begin
    if (!arst_n) begin
      hdr_cnt_r     <= 3'd0;
      dst_r         <= 48'd0;
      src_mac_r     <= 48'd0;
      ethertype_r   <= 16'd0;
      byte_cnt_r    <= 11'd0;
      dl_r          <= 32'd0;
      err_r         <= 1'b0;
      first_r       <= 1'b0;
      data_out_r    <= 8'd0;
      data_valid_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      frame_good_r  <= 1'b0;
    end else begin
      hdr_cnt_r     <= hdr_cnt_s;
      dst_r         <= dst_s;
      src_mac_r     <= src_mac_s;
      ethertype_r   <= ethertype_s;
      byte_cnt_r    <= byte_cnt_s;
      dl_r          <= dl_s;
      err_r         <= err_s;
      first_r       <= first_s;
      data_out_r    <= data_out_s;
      data_valid_r  <= data_valid_s;
      frame_start_r <= frame_start_s;
      frame_end_r   <= frame_end_s;
      frame_good_r  <= frame_good_s;
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.data_valid  = data_valid_r;
  assign bus.frame_start = frame_start_r;
  assign bus.frame_end   = frame_end_r;
  assign bus.frame_good  = frame_good_r;
  assign bus.src_mac     = src_mac_r;
  assign bus.ethertype   = ethertype_r;

endmodule

// File: tb/tb_decapsulation.sv
// Scoreboard bench for decapsulation: frames are built and judged from the
// Ethernet framing rules; a negedge monitor checks every beat and frame_end.
module tb_decapsulation;

  localparam logic [47:0] MAC   = 48'h023528fbdd66;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SRC0  = 48'hA0B1C2D3E4F5;
  localparam int MIN_P = 46;
  localparam int MAX_P = 1500;
`ifdef DECAP_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    bit         start;
    longint     cyc;
  } beat_t;

  typedef struct {
    bit          good;
    bit          hdr;
    logic [47:0] src;
    logic [15:0] et;
    longint      cyc;
  } end_t;

  logic eth_rx_clk = 1'b0;
  logic arst_n;
  longint cyc = 0;
  int checks = 0;
  int failures = 0;
  beat_t exp_beats[$];
  end_t  exp_ends[$];
  logic [7:0] frm[$];

  decapsulation_if bus ();

  decapsulation #(
    .MAC_ADDR    (MAC),
    .MIN_PAYLOAD (MIN_P),
    .MAX_PAYLOAD (MAX_P)
  ) dut (
    .eth_rx_clk (eth_rx_clk),
    .arst_n     (arst_n),
    .bus        (bus)
  );

  always #5 eth_rx_clk = ~eth_rx_clk;

  always @(posedge eth_rx_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Standard Ethernet FCS value over the first n bytes of the frame buffer.
  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                       input int plen, input bit rnd, input bit corrupt);
    logic [31:0] c;
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(src[8*i +: 8]);
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    for (int i = 0; i < plen; i++) frm.push_back(rnd ? 8'($urandom) : 8'(i));
    c = crc_of(frm.size());
    if (corrupt) c[$urandom_range(31, 0)] ^= 1'b1;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  task automatic truncate(input int n);
    while (frm.size() > n) void'(frm.pop_back());
  endtask

  task automatic idle_cycle();
    @(posedge eth_rx_clk); #1;
    arst_n = 1'b1; bus.rx_dv = 1'b0; bus.rx_er = 1'b0; bus.rxd = 8'h00;
  endtask

  // Drive preamble + frame buffer; er_idx/rst_idx are frame byte indices (-1 = none).
  task automatic send(input int er_idx, input int rst_idx, input int ifg);
    int n, plen;
    bit acc, good, aborted;
    logic [47:0] d, s;
    logic [15:0] et;
    logic [31:0] rx_fcs;
    n = frm.size();
    d = 48'd0; s = 48'd0; et = 16'd0;
    for (int i = 0; i < 6 && i < n; i++) d = {d[39:0], frm[i]};
    for (int i = 6; i < 12 && i < n; i++) s = {s[39:0], frm[i]};
    for (int i = 12; i < 14 && i < n; i++) et = {et[7:0], frm[i]};
    acc  = (n >= 6) && ((d == MAC) || (d == BCAST));
    plen = n - 18;
    good = (n >= 18) && !(er_idx >= 0 && er_idx < n) && (plen >= MIN_P) && (plen <= MAX_P);
    if (CRC_EN && n >= 18) begin
      rx_fcs = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
      good = good && (rx_fcs == crc_of(n - 4));
    end
    aborted = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge eth_rx_clk); #1;
      arst_n = 1'b1; bus.rx_dv = 1'b1; bus.rx_er = 1'b0;
      bus.rxd = (i == 7) ? 8'hD5 : 8'h55;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge eth_rx_clk); #1;
      bus.rx_dv = 1'b1; bus.rxd = frm[i]; bus.rx_er = (i == er_idx);
      if (i == rst_idx) begin
        arst_n = 1'b0;
        aborted = 1'b1;
        exp_beats.delete();
        exp_ends.delete();
        #1;
        chk("reset_mid_flags", {60'd0, bus.data_valid, bus.frame_start, bus.frame_end, bus.frame_good}, 64'd0);
        chk("reset_mid_data", {56'd0, bus.data_out}, 64'd0);
        chk("reset_mid_hdr", {bus.src_mac, bus.ethertype}, 64'd0);
      end else begin
        arst_n = 1'b1;
        if (acc && !aborted && i >= 14 && i < n - 4) begin
          exp_beats.push_back('{data: frm[i], start: (i == 14), cyc: cyc + 5});
        end
      end
    end
    idle_cycle();
    if (acc && !aborted) begin
      exp_ends.push_back('{good: good, hdr: (n >= 14), src: s, et: et, cyc: cyc + 1});
    end
    for (int k = 1; k < ifg; k++) idle_cycle();
  endtask

  // Scoreboard monitor, sampling on the inactive edge.
  always @(negedge eth_rx_clk) begin
    if (arst_n) begin
      if (bus.data_valid) begin
        if (exp_beats.size() == 0) begin
          chk("unexpected_data_valid", 64'd1, 64'd0);
        end else begin
          beat_t b;
          b = exp_beats.pop_front();
          chk("beat_data", {56'd0, bus.data_out}, {56'd0, b.data});
          chk("beat_start", {63'd0, bus.frame_start}, {63'd0, b.start});
          chk("beat_cycle", 64'(cyc), 64'(b.cyc));
        end
      end else if (bus.frame_start) begin
        chk("frame_start_without_data", 64'd1, 64'd0);
      end
      if (bus.frame_end) begin
        if (exp_ends.size() == 0) begin
          chk("unexpected_frame_end", 64'd1, 64'd0);
        end else begin
          end_t e;
          e = exp_ends.pop_front();
          chk("frame_good", {63'd0, bus.frame_good}, {63'd0, e.good});
          chk("frame_end_cycle", 64'(cyc), 64'(e.cyc));
          if (e.hdr) begin
            chk("src_mac", {16'd0, bus.src_mac}, {16'd0, e.src});
            chk("ethertype", {48'd0, bus.ethertype}, {48'd0, e.et});
          end
        end
      end
    end
  end

  initial begin
    int n, er;
    logic [47:0] d;
    arst_n = 1'b0;
    bus.rx_dv = 1'b0; bus.rx_er = 1'b0; bus.rxd = 8'h00;
    repeat (3) @(negedge eth_rx_clk);
    chk("rst_data_out", {56'd0, bus.data_out}, 64'd0);
    chk("rst_data_valid", {63'd0, bus.data_valid}, 64'd0);
    chk("rst_frame_start", {63'd0, bus.frame_start}, 64'd0);
    chk("rst_frame_end", {63'd0, bus.frame_end}, 64'd0);
    chk("rst_frame_good", {63'd0, bus.frame_good}, 64'd0);
    chk("rst_src_mac", {16'd0, bus.src_mac}, 64'd0);
    chk("rst_ethertype", {48'd0, bus.ethertype}, 64'd0);
    idle_cycle();
    idle_cycle();

    build(MAC, SRC0, 16'h0800, 46, 1'b0, 1'b0);   send(-1, -1, 2);
    build(MAC, SRC0, 16'h0800, 46, 1'b0, 1'b1);   send(-1, -1, 2);
    build(48'h112233445566, SRC0, 16'h0800, 46, 1'b0, 1'b0); send(-1, -1, 1);
    build(BCAST, 48'h0A0B0C0D0E0F, 16'h0806, 46, 1'b1, 1'b0); send(-1, -1, 1);
    build(MAC, SRC0, 16'h0800, 46, 1'b0, 1'b0);   send(24, -1, 2);
    build(MAC, SRC0, 16'h86DD, 20, 1'b1, 1'b0);   send(-1, -1, 1);
    build(MAC, SRC0, 16'h0800, 1501, 1'b1, 1'b0); send(-1, -1, 1);
    build(MAC, SRC0, 16'h0800, 1500, 1'b1, 1'b0); send(-1, -1, 1);
    build(MAC, SRC0, 16'h0800, 45, 1'b1, 1'b0);   send(-1, -1, 1);
    build(MAC, SRC0, 16'h0800, 46, 1'b0, 1'b0);   send(-1, 19, 3);
    build(MAC, SRC0, 16'h0800, 46, 1'b0, 1'b0);   send(-1, -1, 1);
    build(MAC, SRC0, 16'h1234, 0, 1'b1, 1'b0); truncate(16); send(-1, -1, 1);
    build(BCAST, SRC0, 16'h1234, 46, 1'b1, 1'b0); truncate(9); send(-1, -1, 1);
    build(MAC, SRC0, 16'h1234, 46, 1'b1, 1'b0); truncate(3); send(-1, -1, 1);

    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 3))
        0, 1:    d = MAC;
        2:       d = BCAST;
        default: d = {16'($urandom), 32'($urandom)};
      endcase
      build(d, {16'($urandom), 32'($urandom)}, 16'($urandom), int'($urandom_range(40, 60)),
            1'b1, ($urandom_range(0, 3) == 0));
      n  = frm.size();
      er = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      send(er, -1, int'($urandom_range(1, 3)));
    end

    repeat (12) idle_cycle();
    chk("beats_drained", 64'(exp_beats.size()), 64'd0);
    chk("ends_drained", 64'(exp_ends.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decapsulation.md
DECAPSULATION -- requirements
Module: decapsulation

Interface
REQ-001 SHALL have parameter MAC_ADDR, default 48'h023528fbdd66: local station address for the destination filter.
REQ-002 SHALL have parameter MIN_PAYLOAD, default 46: minimum legal payload byte count.
REQ-003 SHALL have parameter MAX_PAYLOAD, default 1500: maximum legal payload byte count.
REQ-004 eth_rx_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 arst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 rx_dv  in  1  GMII receive data valid.
REQ-007 rx_er  in  1  GMII receive error.
REQ-008 rxd  in  8  GMII receive byte.
REQ-009 data_out  out  8  payload byte, FCS stripped.
REQ-010 data_valid  out  1  data_out holds a payload byte this cycle.
REQ-011 frame_start  out  1  one-cycle pulse coincident with the first payload byte.
REQ-012 frame_end  out  1  one-cycle pulse after the last payload byte of an accepted frame.
REQ-013 frame_good  out  1  frame status, valid only while frame_end=1.
REQ-014 src_mac  out  48  captured source address; stable from TYPE until the next frame reaches SRC.
REQ-015 ethertype  out  16  captured type/length field, big-endian; same stability rule as src_mac.

Function
REQ-016 SHALL implement FSM states IDLE, PREAMBLE, DST, SRC, TYPE, PAYLOAD, DROP.
REQ-017 IDLE: rx_dv=1 and rxd=8'h55 -> PREAMBLE; any other input stays in IDLE.
REQ-018 PREAMBLE: 8'h55 -> stay; 8'hD5 -> DST; any other byte, or rx_dv=0 -> DROP or IDLE respectively.
REQ-019 DST: capture 6 bytes, MSB-first. After the 6th byte, a match with MAC_ADDR or 48'hFFFFFFFFFFFF -> SRC; otherwise -> DROP.
REQ-020 SRC: capture 6 bytes into src_mac, then -> TYPE. TYPE: capture 2 bytes into ethertype, then -> PAYLOAD.
REQ-021 DROP: no outputs asserted; wait for rx_dv=0 -> IDLE.
REQ-022 rx_dv=0 in DST: -> IDLE silently. rx_dv=0 in SRC, TYPE or PAYLOAD: end of frame; -> IDLE and pulse frame_end on the next cycle.
REQ-023 PAYLOAD bytes SHALL pass through a 4-byte delay line. A byte is emitted only when a 5th byte arrives behind it, so the 4 FCS bytes are never emitted.
REQ-024 Latency: with rx_dv continuous, a payload byte sampled at cycle t appears on data_out with data_valid=1 at cycle t+5.
REQ-025 The byte counter (11 bits, saturating at 2047) SHALL count PAYLOAD bytes including FCS; payload length = count-4.
REQ-026 frame_good=1 only if all hold: no rx_er sampled from DST through end of frame; MIN_PAYLOAD <= length <= MAX_PAYLOAD; CRC OK (REQ-032).
REQ-027 Fewer than 4 bytes in PAYLOAD: frame_end with frame_good=0 and no data_valid.
REQ-028 A new preamble arriving the cycle after frame_end SHALL be accepted; there is no back-to-back penalty.
REQ-029 CRC-32 (poly 0x04C11DB7, reflected, init 32'hFFFFFFFF) SHALL run over DST through the FCS bytes, one byte per cycle.

Reset
REQ-030 While arst_n=0: state=IDLE; data_out=0, data_valid=0, frame_start=0, frame_end=0, frame_good=0, src_mac=0, ethertype=0; counter, delay line and error flag cleared; CRC=32'hFFFFFFFF.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no frame_end. After release, the remainder of that frame is ignored until a fresh 55/D5 sequence.

Configuration
REQ-032 Macro DECAP_CRC_CHECK_EN defined: CRC logic present; CRC OK means the register equals 32'hDEBB20E3 after the last byte. Undefined: no CRC logic; CRC OK is treated as always true; FCS is still stripped.

Verification
REQ-033 Frame to dst 023528fbdd66, type 0800, 46 payload bytes 00..2D, correct FCS: 46 data_valid beats 00..2D, frame_start with byte 00, frame_end with frame_good=1, ethertype=16'h0800.
REQ-034 Same frame with one FCS bit flipped: identical data beats, frame_good=0 with the macro defined and frame_good=1 without it.
REQ-035 Frame to dst 112233445566: no data_valid, no frame_end; the following broadcast frame is accepted with frame_good=1.
REQ-036 Valid 46-byte frame with rx_er=1 for one cycle at payload byte 10: all beats emitted, frame_good=0.
REQ-037 Runt frame with 20 payload bytes plus FCS: 20 beats, frame_good=0. 1501-byte payload: frame_good=0.
REQ-038 arst_n pulsed low at payload byte 5: outputs zero immediately, no frame_end; the next full frame gives frame_good=1.
